imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Program loader for the instruction (Text) memory.
- Fetch only ever reads Text memory; this block is its writer.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Drives the Text memory write port (w_addr/w_en/din) and holds the core in reset until the load completes.

Parameters:
- ADDR_W, 10, Text memory word-address width (matches 10-bit PC).
- BASE_ADDR, 0, first word address written.
- DEPTH, 1024, number of writable words; must be ≤ 2^ADDR_W.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begins a load from IDLE or DONE/ERROR
- byte_valid  in  1  upstream byte present
- byte_data  in  8  upstream byte
- byte_ready  out  1  loader accepts byte this cycle (transfer = valid & ready)
- w_addr  out  ADDR_W  Text memory write word address
- w_en  out  1  Text memory write strobe, one cycle per word
- din  out  32  Text memory write data
- cpu_hold  out  1  active-high reset to core; high while loading
- busy  out  1  load in progress
- done  out  1  level; last load completed cleanly
- err  out  1  level; last load aborted
- word_count  out  16  words written in current/last load

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE, byte_ready=0, w_en=0, w_addr=BASE_ADDR, din=0, word_count=0, done=0, err=0, busy=0.
  - cpu_hold=1: core stays held until the first successful load.
- States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHK (optional), DONE, ERROR.
- IDLE/DONE/ERROR + start: go to LEN_HI; clear done, err, word_count; set w_addr=BASE_ADDR, busy=1, cpu_hold=1.
- start is ignored while busy.
- LEN_HI, LEN_LO: byte_ready=1; each accepted byte forms 16-bit N = {hi, lo}.
  - On LEN_LO accept:
    - N==0: go to DONE (or CHK if enabled).
    - N>DEPTH: go to ERROR.
    - Otherwise: go to DATA with byte index 0.
- DATA: byte_ready=1.
  - Bytes are shifted in MSB-first: byte 0 → din[31:24], byte 3 → din[7:0].
  - On the 4th accepted byte go to WRITE.
- WRITE (exactly one cycle): byte_ready=0, w_en=1, din and w_addr stable; word_count++.
  - Next cycle: w_addr++ and return to DATA.
  - After the Nth word, go to DONE (or CHK) instead.
- w_addr wraps modulo 2^ADDR_W; wrap is unreachable when BASE_ADDR+DEPTH ≤ 2^ADDR_W. That inequality is a parameter legality rule, checked by assertion.
- DONE: busy=0, done=1, cpu_hold=0 in the same cycle done rises; byte_ready=0.
- ERROR: busy=0, err=1, cpu_hold stays 1, byte_ready=0.
  - Words already written are not rolled back.
- byte_valid low only stalls the block; no timeout.
- byte_ready never depends combinationally on byte_valid.
- Throughput: 5 cycles per word at full rate (4 accepts + 1 WRITE).
- Reset mid-load: immediate return to reset values. Partial memory contents are left as-is; core stays held.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
  - Defined: the stream ends with one checksum byte equal to the XOR of all N*4 data bytes (0x00 when N==0). The checksum byte is accepted in CHK. Match → DONE; mismatch → ERROR.
  - Undefined: no CHK state and no trailer byte; the stream ends after the last data byte.

Decomposition:
- Shared package (processor package): state enum, TEXT_ADDR_W=10, INSTR_W=32.
- One natural sub-module: loader_word_asm. It is a 4-byte shift register with byte index counter, word_ready pulse and clear. The FSM, address counter and checksum stay in imem_loader.

Test Plan:
- Reset then start, stream 00 02 | 20 01 00 05 | 8C 22 00 04 → w_en pulses twice: addr 0 din 0x20010005, addr 1 din 0x8C220004; word_count=2; done=1; cpu_hold falls with done.
- Same stream with byte_valid toggled randomly 50% → identical writes and order; no byte lost or duplicated; w_en never asserted with byte_ready high.
- Length 04 01 (1025) with DEPTH=1024 → ERROR after second byte; no w_en; err=1; cpu_hold=1; a later start with a good stream recovers.
- Length 00 00 → DONE two accepts after start; zero writes; with LOADER_CHECKSUM_EN, also send 00 → done. Sending 5A instead → err.
- rst=0 asserted after 2 of 3 words written → all outputs at reset values next cycle; new load from BASE_ADDR writes correctly.
- LOADER_CHECKSUM_EN, one word 11 22 33 44, checksum 44 → done=1; checksum 45 → err=1, word already written at addr 0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared processor definitions for the Text memory loader: widths and loader FSM states.
package imem_loader_pkg;

  localparam int TEXT_ADDR_W = 10;
  localparam int INSTR_W     = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERROR
  } state_e;

endpackage

// File: rtl/loader_word_asm.sv
// Big-endian word assembler: four accepted bytes shift in MSB-first; word_ready_o marks the 4th.
// Latency: word is complete the cycle after the 4th shift; no backpressure of its own.
module loader_word_asm
  import imem_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               shift_en_i,
  input  logic [7:0]         byte_i,
  output logic [INSTR_W-1:0] word_o,
  output logic               word_ready_o
);

  logic [1:0]         idx_q, idx_d;
  logic [INSTR_W-1:0] word_q, word_d;

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clr_i) begin
      idx_d = 2'd0;
    end else if (shift_en_i) begin
      word_d = {word_q[INSTR_W-9:0], byte_i};
      idx_d  = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_q  <= 2'd0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  assign word_o       = word_q;
  assign word_ready_o = shift_en_i && !clr_i && (idx_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Text memory program loader: {len_hi, len_lo, N*4 data bytes [, xor checksum]} -> one write per word.
// 5 cycles per word at full rate; byte_ready is state-only, byte_valid low just stalls. Trailer: LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = TEXT_ADDR_W,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               byte_ready,
  output logic [ADDR_W-1:0]  w_addr,
  output logic               w_en,
  output logic [INSTR_W-1:0] din,
  output logic               cpu_hold,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [15:0]        word_count
);

  if (BASE_ADDR + DEPTH > (1 << ADDR_W)) begin : g_param_check
    $error("imem_loader: BASE_ADDR + DEPTH must not exceed 2**ADDR_W");
  end

  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
  localparam logic [16:0]       DEPTH_L = 17'(DEPTH);
`ifdef LOADER_CHECKSUM_EN
  localparam state_e END_ST = S_CHK;
`else
  localparam state_e END_ST = S_DONE;
`endif

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              hold_q, hold_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        chk_q, chk_d;
`endif

  logic              accept;
  logic              asm_clr;
  logic              asm_shift;
  logic              word_ready;
  logic [16:0]       len_new;

  assign byte_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                      (state_q == S_DATA)   || (state_q == S_CHK);
  assign accept     = byte_valid && byte_ready;
  assign len_new    = {1'b0, len_q[15:8], byte_data};

  loader_word_asm u_word_asm (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (asm_clr),
    .shift_en_i   (asm_shift),
    .byte_i       (byte_data),
    .word_o       (din),
    .word_ready_o (word_ready)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    done_d    = done_q;
    err_d     = err_q;
    hold_d    = hold_q;
    asm_clr   = 1'b0;
    asm_shift = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    chk_d     = chk_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_LEN_HI;
          done_d  = 1'b0;
          err_d   = 1'b0;
          cnt_d   = 16'd0;
          addr_d  = BASE_A;
          hold_d  = 1'b1;
          asm_clr = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          chk_d   = 8'd0;
`endif
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d[15:8] = byte_data;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d[7:0] = byte_data;
          asm_clr    = 1'b1;
          if (len_new == 17'd0)        state_d = END_ST;
          else if (len_new > DEPTH_L)  state_d = S_ERROR;
          else                         state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          asm_shift = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          chk_d     = chk_q ^ byte_data;
`endif
          if (word_ready) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        cnt_d   = cnt_q + 16'd1;
        addr_d  = addr_q + ADDR_W'(1);
        state_d = (cnt_d == len_q) ? END_ST : S_DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) state_d = (byte_data == chk_q) ? S_DONE : S_ERROR;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // done/err are levels that rise on entry; the core is released only on a clean finish
    if (state_d == S_DONE && state_q != S_DONE) begin
      done_d = 1'b1;
      hold_d = 1'b0;
    end
    if (state_d == S_ERROR && state_q != S_ERROR) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      len_q   <= 16'd0;
      cnt_q   <= 16'd0;
      addr_q  <= BASE_A;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      chk_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
`ifdef LOADER_CHECKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

  assign w_en       = (state_q == S_WRITE);
  assign w_addr     = addr_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
  assign done       = done_q;
  assign err        = err_q;
  assign cpu_hold   = hold_q;
  assign word_count = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: streams framed programs and compares writes to a byte-level model.
module tb_imem_loader;

  localparam int ADDR_W    = 10;
  localparam int BASE_ADDR = 0;
  localparam int DEPTH     = 1024;
`ifdef LOADER_CHECKSUM_EN
  localparam int CHK_BYTES = 1;
`else
  localparam int CHK_BYTES = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic [ADDR_W-1:0] w_addr;
  logic              w_en;
  logic [31:0]       din;
  logic              cpu_hold, busy, done, err;
  logic [15:0]       word_count;

  imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .w_addr(w_addr), .w_en(w_en), .din(din), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .err(err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_dat[$];
  int                consumed, overlap, hold_bad;
  bit                timeout;

  // Stream = length (big-endian), data bytes, then xor trailer when the checksum build is used.
  function automatic void make_stream(input int n, input logic [7:0] data[$], output logic [7:0] s[$]);
    logic [7:0] x;
    logic [15:0] nn;
    x = 8'h00;
    nn = 16'(n);
    s = {};
    s.push_back(nn[15:8]);
    s.push_back(nn[7:0]);
    foreach (data[i]) begin
      s.push_back(data[i]);
      x = x ^ data[i];
    end
    if (CHK_BYTES == 1) s.push_back(x);
  endfunction

  function automatic logic [31:0] exp_word(input logic [7:0] data[$], input int i);
    return {data[4*i], data[4*i+1], data[4*i+2], data[4*i+3]};
  endfunction

  task automatic stream(input logic [7:0] s[$], input bit rnd, input int abort_writes);
    int cyc;
    wr_addr.delete(); wr_dat.delete();
    consumed = 0; overlap = 0; hold_bad = 0; timeout = 0; cyc = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (!(done || err)) begin
      if (w_en) begin
        wr_addr.push_back(w_addr);
        wr_dat.push_back(din);
      end
      if (w_en && byte_ready) overlap++;
      if (busy && !cpu_hold) hold_bad++;
      if (abort_writes > 0 && wr_addr.size() == abort_writes) begin
        byte_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        break;
      end
      if (cyc >= 3000) begin
        timeout = 1;
        break;
      end
      byte_valid = (consumed < s.size()) && (!rnd || $urandom_range(0, 1) == 1);
      byte_data  = byte_valid ? s[consumed] : 8'($urandom);
      if (byte_valid && byte_ready) consumed++;
      @(negedge clk);
      cyc++;
    end
    byte_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(negedge clk);
    n_checks++; if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL reset_byte_ready: got %b expected 0", byte_ready); end
    n_checks++; if (w_en !== 1'b0) begin n_fail++; $display("FAIL reset_w_en: got %b expected 0", w_en); end
    n_checks++; if (w_addr !== ADDR_W'(BASE_ADDR)) begin n_fail++; $display("FAIL reset_w_addr: got %0h expected %0h", w_addr, BASE_ADDR); end
    n_checks++; if (din !== 32'h0) begin n_fail++; $display("FAIL reset_din: got %h expected 0", din); end
    n_checks++; if (word_count !== 16'd0) begin n_fail++; $display("FAIL reset_word_count: got %0d expected 0", word_count); end
    n_checks++; if ({done, err, busy} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got done/err/busy=%b expected 000", {done, err, busy}); end
    n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_hold: got %b expected 1", cpu_hold); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Full-rate or stalled load of a known two-word program.
  task automatic test_basic(input bit rnd, input string tag);
    logic [7:0] data[$];
    logic [7:0] s[$];
    data = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h8C, 8'h22, 8'h00, 8'h04};
    make_stream(2, data, s);
    stream(s, rnd, 0);
    n_checks++; if (timeout) begin n_fail++; $display("FAIL %s_timeout: got no done/err expected done", tag); end
    n_checks++; if (wr_addr.size() != 2) begin n_fail++; $display("FAIL %s_writes: got %0d expected 2", tag, wr_addr.size()); end
    for (int i = 0; i < 2 && i < wr_addr.size(); i++) begin
      n_checks++; if (wr_addr[i] !== ADDR_W'(BASE_ADDR + i)) begin n_fail++; $display("FAIL %s_addr%0d: got %0h expected %0h", tag, i, wr_addr[i], BASE_ADDR + i); end
      n_checks++; if (wr_dat[i] !== exp_word(data, i)) begin n_fail++; $display("FAIL %s_din%0d: got %h expected %h", tag, i, wr_dat[i], exp_word(data, i)); end
    end
    n_checks++; if (word_count !== 16'd2) begin n_fail++; $display("FAIL %s_word_count: got %0d expected 2", tag, word_count); end
    n_checks++; if ({done, err, busy, cpu_hold} !== 4'b1000) begin n_fail++; $display("FAIL %s_end_flags: got done/err/busy/hold=%b expected 1000", tag, {done, err, busy, cpu_hold}); end
    n_checks++; if (consumed != s.size()) begin n_fail++; $display("FAIL %s_consumed: got %0d expected %0d", tag, consumed, s.size()); end
    n_checks++; if (overlap != 0 || hold_bad != 0) begin n_fail++; $display("FAIL %s_overlap_hold: got %0d/%0d expected 0/0", tag, overlap, hold_bad); end
  endtask

  task automatic test_random_loads;
    logic [7:0] data[$];
    logic [7:0] s[$];
    int n;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 7);
      data = {};
      for (int b = 0; b < 4 * n; b++) data.push_back(8'($urandom));
      make_stream(n, data, s);
      stream(s, it[0], 0);
      n_checks++; if (wr_addr.size() != n || timeout) begin n_fail++; $display("FAIL rand%0d_writes: got %0d expected %0d", it, wr_addr.size(), n); end
      for (int i = 0; i < n && i < wr_addr.size(); i++) begin
        n_checks++;
        if (wr_addr[i] !== ADDR_W'(BASE_ADDR + i) || wr_dat[i] !== exp_word(data, i)) begin
          n_fail++; $display("FAIL rand%0d_word%0d: got %0h:%h expected %0h:%h", it, i, wr_addr[i], wr_dat[i], BASE_ADDR + i, exp_word(data, i));
        end
      end
      n_checks++; if (word_count !== 16'(n) || done !== 1'b1 || cpu_hold !== 1'b0) begin n_fail++; $display("FAIL rand%0d_end: got count %0d done %b hold %b expected %0d 1 0", it, word_count, done, cpu_hold, n); end
    end
  endtask

  task automatic test_len_error;
    logic [7:0] s[$];
    s = '{8'h04, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    stream(s, 1'b0, 0);
    n_checks++; if (err !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL lenerr_flags: got err %b done %b expected 1 0", err, done); end
    n_checks++; if (consumed != 2) begin n_fail++; $display("FAIL lenerr_consumed: got %0d expected 2", consumed); end
    n_checks++; if (wr_addr.size() != 0) begin n_fail++; $display("FAIL lenerr_writes: got %0d expected 0", wr_addr.size()); end
    n_checks++; if (cpu_hold !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL lenerr_hold_busy: got %b%b expected 10", cpu_hold, busy); end
    repeat (3) @(negedge clk);
    n_checks++; if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL lenerr_ready: got %b expected 0", byte_ready); end
    test_basic(1'b0, "recover");
  endtask

  task automatic test_zero_len;
    logic [7:0] s[$];
    logic [7:0] none[$];
    none = {};
    make_stream(0, none, s);
    stream(s, 1'b0, 0);
    n_checks++; if (done !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL zero_flags: got done %b err %b expected 1 0", done, err); end
    n_checks++; if (consumed != 2 + CHK_BYTES || wr_addr.size() != 0) begin n_fail++; $display("FAIL zero_traffic: got %0d bytes %0d writes expected %0d 0", consumed, wr_addr.size(), 2 + CHK_BYTES); end
    n_checks++; if (word_count !== 16'd0 || cpu_hold !== 1'b0) begin n_fail++; $display("FAIL zero_end: got count %0d hold %b expected 0 0", word_count, cpu_hold); end
  endtask

  task automatic test_reset_mid_load;
    logic [7:0] data[$];
    logic [7:0] s[$];
    for (int b = 0; b < 12; b++) data.push_back(8'($urandom));
    make_stream(3, data, s);
    stream(s, 1'b0, 2);
    n_checks++; if (wr_addr.size() != 2) begin n_fail++; $display("FAIL midrst_writes: got %0d expected 2", wr_addr.size()); end
    n_checks++; if ({byte_ready, w_en, busy, done, err} !== 5'b0) begin n_fail++; $display("FAIL midrst_ctrl: got %b expected 00000", {byte_ready, w_en, busy, done, err}); end
    n_checks++; if (w_addr !== ADDR_W'(BASE_ADDR) || din !== 32'h0 || word_count !== 16'd0) begin n_fail++; $display("FAIL midrst_data: got %0h %h %0d expected %0h 0 0", w_addr, din, word_count, BASE_ADDR); end
    n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL midrst_hold: got %b expected 1", cpu_hold); end
    rst = 1'b1;
    @(negedge clk);
    test_basic(1'b1, "after_rst");
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum;
    logic [7:0] s[$];
    s = '{8'h00, 8'h00, 8'h5A};
    stream(s, 1'b0, 0);
    n_checks++; if (err !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL chk_zero_bad: got err %b done %b expected 1 0", err, done); end
    s = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    stream(s, 1'b0, 0);
    n_checks++; if (done !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL chk_good: got done %b err %b expected 1 0", done, err); end
    s = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    stream(s, 1'b1, 0);
    n_checks++; if (err !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1) begin n_fail++; $display("FAIL chk_bad: got err %b done %b hold %b expected 1 0 1", err, done, cpu_hold); end
    n_checks++; if (wr_addr.size() != 1 || wr_dat[0] !== 32'h11223344) begin n_fail++; $display("FAIL chk_bad_write: got %0d writes expected 1 of 11223344", wr_addr.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic(1'b0, "basic");
    test_basic(1'b1, "stall");
    test_random_loads();
    test_len_error();
    test_zero_len();
    test_reset_mid_load();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
